// File: rtl/dsp48_mac_sequencer.sv
// Sequences one DSP48A1 slice as an N-term multiply-accumulator.
// Define MAC_TIMEOUT_EN to abort stalled jobs after TIMEOUT idle FEED cycles.
module dsp48_mac_sequencer #(
  parameter int CNT_W   = 16,
  parameter int MUL_LAT = 2,
  parameter int TIMEOUT = 64
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             start,
  input  logic [CNT_W-1:0] len,
  output logic             busy,
  input  logic             op_valid,
  output logic             op_ready,
  output logic             CEAB,
  output logic             CEM,
  output logic             CEP,
  output logic [7:0]       OPMODE,
  output logic             RSTP,
  input  logic [47:0]      P_IN,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [47:0]      res_data
`ifdef MAC_TIMEOUT_EN
  ,
  output logic             timeout_err
`endif
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_FEED,
    S_DRAIN,
    S_CAPT,
    S_HOLD
  } state_t;

  state_t state, nxt;

  logic [CNT_W-1:0]   rem;
  logic               first_q;
  logic [MUL_LAT-1:0] pipe_v;
  logic [MUL_LAT-1:0] pipe_f;
  logic               abort;

  assign CEAB = op_valid & op_ready;
  assign CEM  = busy;
  assign CEP  = pipe_v[MUL_LAT-1];

`ifdef MAC_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);

  logic [TW-1:0] stall_cnt;
  logic          tmo_q;

  assign abort = (state == S_FEED) && op_ready && !op_valid
              && (stall_cnt == TW'(TIMEOUT - 1));

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      stall_cnt   <= '0;
      tmo_q       <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      if (state != S_FEED || CEAB)
        stall_cnt <= '0;
      else if (op_ready && !op_valid)
        stall_cnt <= stall_cnt + TW'(1);
      if (state == S_CLEAR)
        tmo_q <= 1'b0;
      else if (abort)
        tmo_q <= 1'b1;
      if (state == S_CAPT)
        timeout_err <= tmo_q;
      else if (state == S_HOLD && res_ready)
        timeout_err <= 1'b0;
    end
  end
`else
  assign abort = 1'b0;
`endif

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)
      state <= S_IDLE;
    else
      state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      S_IDLE:  if (start) nxt = S_CLEAR;
      S_CLEAR: nxt = (rem != '0) ? S_FEED : S_DRAIN;
      S_FEED:  if (rem == '0 || abort) nxt = S_DRAIN;
      S_DRAIN: if (pipe_v == '0) nxt = S_CAPT;
      S_CAPT:  nxt = S_HOLD;
      S_HOLD:  if (res_ready) nxt = S_IDLE;
      default: nxt = S_IDLE;
    endcase
  end

  // Empty tap keeps Z=P so P simply holds while CEP is low
  always_comb begin
    busy     = (state != S_IDLE);
    op_ready = (state == S_FEED) && (rem != '0);
    RSTP     = (state == S_CLEAR);
    OPMODE   = 8'h00;
    if (state != S_IDLE)
      OPMODE = (CEP && pipe_f[MUL_LAT-1]) ? 8'h01 : 8'h09;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      rem       <= '0;
      first_q   <= 1'b0;
      pipe_v    <= '0;
      pipe_f    <= '0;
      res_valid <= 1'b0;
      res_data  <= '0;
    end else begin
      if (state == S_IDLE && start)
        rem <= len;
      else if (CEAB)
        rem <= rem - CNT_W'(1);
      if (state == S_CLEAR)
        first_q <= 1'b1;
      else if (CEAB)
        first_q <= 1'b0;
      pipe_v[0] <= CEAB;
      pipe_f[0] <= CEAB & first_q;
      for (int i = 1; i < MUL_LAT; i++) begin
        pipe_v[i] <= pipe_v[i-1];
        pipe_f[i] <= pipe_f[i-1];
      end
      if (state == S_CAPT) begin
        res_data  <= P_IN;
        res_valid <= 1'b1;
      end else if (state == S_HOLD && res_ready) begin
        res_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_dsp48_mac_sequencer.sv
// Bench for dsp48_mac_sequencer with a behavioural DSP48A1 slice.
// Exercises directed jobs, stalls, reset abort and random jobs.
module tb_dsp48_mac_sequencer;

  localparam int CNT_W   = 16;
  localparam int MUL_LAT = 2;
  localparam int TIMEOUT = 8;

  logic             CLK = 1'b0;
  logic             RST_N = 1'b0;
  logic             start = 1'b0;
  logic [CNT_W-1:0] len = '0;
  logic             busy;
  logic             op_valid = 1'b0;
  logic             op_ready;
  logic             CEAB, CEM, CEP, RSTP;
  logic [7:0]       OPMODE;
  logic [47:0]      P_IN;
  logic             res_valid;
  logic             res_ready = 1'b0;
  logic [47:0]      res_data;
`ifdef MAC_TIMEOUT_EN
  logic             timeout_err;
`endif

  logic [17:0] A = '0, B = '0;
  logic [17:0] a_r, b_r;
  logic [35:0] m_r;
  logic [47:0] p;

  int total = 0;
  int bad = 0;
  int cep_n = 0;
  int rstp_n = 0;

  logic [17:0] qa[$];
  logic [17:0] qb[$];

  dsp48_mac_sequencer #(
    .CNT_W(CNT_W), .MUL_LAT(MUL_LAT), .TIMEOUT(TIMEOUT)
  ) dut (
    .CLK(CLK), .RST_N(RST_N), .start(start), .len(len),
    .busy(busy), .op_valid(op_valid), .op_ready(op_ready),
    .CEAB(CEAB), .CEM(CEM), .CEP(CEP), .OPMODE(OPMODE),
    .RSTP(RSTP), .P_IN(P_IN), .res_valid(res_valid),
    .res_ready(res_ready), .res_data(res_data)
`ifdef MAC_TIMEOUT_EN
    , .timeout_err(timeout_err)
`endif
  );

  always #5 CLK = ~CLK;

  // Slice: A/B reg -> M reg -> P reg with Z mux (OPMODE[3:2])
  assign P_IN = p;
  always @(posedge CLK) begin
    if (CEAB) begin
      a_r <= A;
      b_r <= B;
    end
    if (CEM) m_r <= a_r * b_r;
    if (RSTP) p <= '0;
    else if (CEP)
      p <= ((OPMODE[3:2] == 2'b10) ? p : 48'd0) + {12'd0, m_r};
    if (CEP) cep_n <= cep_n + 1;
    if (RSTP) rstp_n <= rstp_n + 1;
  end

  task automatic chk(input string tag, input logic [47:0] obs,
                     input logic [47:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [47:0] ref_sum();
    logic [47:0] s = '0;
    foreach (qa[i]) s += 48'(qa[i]) * 48'(qb[i]);
    return s;
  endfunction

  task automatic run_job(input int n, input int gap_after,
                         input int gap_len, input bit start_feed,
                         input int hold_wait, input bit start_hold,
                         output logic [47:0] res, output int lat);
    int idx, gapc, budget, c0, r0;
    bit acc;
    @(negedge CLK);
    c0 = cep_n;
    r0 = rstp_n;
    start = 1'b1;
    len = n[CNT_W-1:0];
    @(posedge CLK);
    @(negedge CLK);
    start = 1'b0;
    idx = 0;
    gapc = 0;
    budget = 0;
    while (idx < n && budget < 300) begin
      if (idx == gap_after && gapc < gap_len && op_ready) begin
        op_valid = 1'b0;
        gapc++;
      end else begin
        op_valid = 1'b1;
        A = qa[idx];
        B = qb[idx];
      end
      start = start_feed && (idx == 1);
      #1 acc = CEAB;
      @(posedge CLK);
      if (acc) idx++;
      budget++;
      @(negedge CLK);
      start = 1'b0;
    end
    chk("feed_done", 48'(idx), 48'(n));
    op_valid = 1'b0;
    lat = 0;
    while (lat < 50) begin
      @(posedge CLK);
      lat++;
      @(negedge CLK);
      if (res_valid) break;
    end
    chk("res_valid_up", 48'(res_valid), 48'd1);
    res = res_data;
`ifdef MAC_TIMEOUT_EN
    chk("tmo_low", 48'(timeout_err), 48'd0);
`endif
    for (int i = 0; i < hold_wait; i++) begin
      start = start_hold && (i == 0);
      @(posedge CLK);
      @(negedge CLK);
      start = 1'b0;
      chk("hold_valid", 48'(res_valid), 48'd1);
      chk("hold_data", res_data, res);
    end
    res_ready = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    res_ready = 1'b0;
    chk("rv_clear", 48'(res_valid), 48'd0);
    @(posedge CLK);
    @(negedge CLK);
    chk("idle", 48'(busy), 48'd0);
    chk("cep_count", 48'(cep_n - c0), 48'(n));
    chk("rstp_count", 48'(rstp_n - r0), 48'd1);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_busy"}, 48'(busy), 48'd0);
    chk({tag, "_opready"}, 48'(op_ready), 48'd0);
    chk({tag, "_ceab"}, 48'(CEAB), 48'd0);
    chk({tag, "_cem"}, 48'(CEM), 48'd0);
    chk({tag, "_cep"}, 48'(CEP), 48'd0);
    chk({tag, "_rstp"}, 48'(RSTP), 48'd0);
    chk({tag, "_opmode"}, 48'(OPMODE), 48'd0);
    chk({tag, "_rvalid"}, 48'(res_valid), 48'd0);
    chk({tag, "_rdata"}, res_data, 48'd0);
  endtask

  initial begin
    logic [47:0] res;
    int lat, n, idx, budget;
    bit acc;

    // Power-on reset
    repeat (3) @(negedge CLK);
    chk_reset_vals("por");
    RST_N = 1'b1;

    // Directed job, no stalls
    qa = {18'd2, 18'd4, 18'd1, 18'd10};
    qb = {18'd3, 18'd5, 18'd1, 18'd10};
    run_job(4, 99, 0, 1'b0, 0, 1'b0, res, lat);
    chk("job4_sum", res, 48'd127);
    chk("job4_lat", 48'(lat), 48'(MUL_LAT + 2));

    // Same job with a 3-cycle bubble after pair 2
    run_job(4, 2, 3, 1'b0, 0, 1'b0, res, lat);
    chk("gap_sum", res, 48'd127);
    chk("gap_lat", 48'(lat), 48'(MUL_LAT + 2));

    // len=0 after P was left at 127
    run_job(0, 99, 0, 1'b0, 0, 1'b0, res, lat);
    chk("len0_sum", res, 48'd0);

    // Start pulses in FEED and HOLD, slow consumer
    qa = {18'd9, 18'd8, 18'd7};
    qb = {18'd1, 18'd2, 18'd3};
    run_job(3, 99, 0, 1'b1, 5, 1'b1, res, lat);
    chk("ign_sum", res, 48'd46);

    // Asynchronous reset after 2 accepts
    qa = {18'd5, 18'd6, 18'd7, 18'd8};
    @(negedge CLK);
    start = 1'b1;
    len = 16'd4;
    @(posedge CLK);
    @(negedge CLK);
    start = 1'b0;
    idx = 0;
    budget = 0;
    while (idx < 2 && budget < 50) begin
      op_valid = 1'b1;
      A = qa[idx];
      B = qa[idx];
      #1 acc = CEAB;
      @(posedge CLK);
      if (acc) idx++;
      budget++;
      @(negedge CLK);
    end
    chk("pre_rst_accepts", 48'(idx), 48'd2);
    RST_N = 1'b0;
    #1 chk_reset_vals("mid");
    op_valid = 1'b0;
    @(negedge CLK);
    RST_N = 1'b1;

    qa = {18'd3, 18'd1};
    qb = {18'd3, 18'd2};
    run_job(2, 99, 0, 1'b0, 0, 1'b0, res, lat);
    chk("post_rst_sum", res, 48'd11);

    // Random jobs against a plain sum-of-products model
    for (int r = 0; r < 6; r++) begin
      n = $urandom_range(1, 8);
      qa.delete();
      qb.delete();
      for (int i = 0; i < n; i++) begin
        qa.push_back(18'($urandom_range(0, 131071)));
        qb.push_back(18'($urandom_range(0, 131071)));
      end
      run_job(n, $urandom_range(1, n), $urandom_range(0, 5), 1'b0,
              $urandom_range(0, 3), 1'b0, res, lat);
      chk("rand_sum", res, ref_sum());
      chk("rand_lat", 48'(lat), 48'(MUL_LAT + 2));
    end

`ifdef MAC_TIMEOUT_EN
    // One accept then a permanent stall
    @(negedge CLK);
    start = 1'b1;
    len = 16'd2;
    @(posedge CLK);
    @(negedge CLK);
    start = 1'b0;
    idx = 0;
    budget = 0;
    while (idx < 1 && budget < 50) begin
      op_valid = 1'b1;
      A = 18'd7;
      B = 18'd6;
      #1 acc = CEAB;
      @(posedge CLK);
      if (acc) idx++;
      budget++;
      @(negedge CLK);
    end
    op_valid = 1'b0;
    budget = 0;
    while (!res_valid && budget < 100) begin
      @(posedge CLK);
      @(negedge CLK);
      budget++;
    end
    chk("tmo_valid", 48'(res_valid), 48'd1);
    chk("tmo_sum", res_data, 48'd42);
    chk("tmo_flag", 48'(timeout_err), 48'd1);
    res_ready = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    res_ready = 1'b0;
    chk("tmo_flag_clr", 48'(timeout_err), 48'd0);
    chk("tmo_rv_clr", 48'(res_valid), 48'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
